cell_painter: RTL and testbench
===============================

CELL_PAINTER -- requirements
Module: cell_painter

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, meaning the number of buffered cell updates (power of two, 2..16).
REQ-002 Parameter CELL_PX, default 20, meaning the cell edge length in pixels.
REQ-003 clk  input  1  system clock; all state changes on the rising edge.
REQ-004 nrst  input  1  asynchronous active-low reset.
REQ-005 diff  input  1  cell-update strobe; one update is offered per cycle while high.
REQ-006 x  input  4  cell column, 0..15.
REQ-007 y  input  4  cell row, 0..11.
REQ-008 obj_code  input  3  object code: 0 blank, 1 border, 2 snake_body, 3 snake_head, 4 apple.
REQ-009 scan_en  output  1  high when the FIFO can accept an update; it drives the scanner's enable.
REQ-010 px_valid  output  1  a pixel write is being offered.
REQ-011 px_ready  input  1  the display sink accepts the offered pixel.
REQ-012 px_x  output  9  pixel column, 0..319.
REQ-013 px_y  output  8  pixel row, 0..239.
REQ-014 px_color  output  16  RGB565 pixel colour.
REQ-015 busy  output  1  high when the FIFO is non-empty or the FSM is not in IDLE.
REQ-016 overflow  output  1  sticky flag: an update was dropped.

Function
REQ-017 scan_en SHALL equal !fifo_full, combinationally.
REQ-018 An update with diff=1, x<=15, y<=11 and FIFO not full SHALL be written as {x,y,obj_code} on the clock edge.
REQ-019 Updates with x>15 or y>11 SHALL be discarded silently; the FIFO and overflow are unchanged.
REQ-020 An update with diff=1 while the FIFO is full SHALL be discarded and SHALL set overflow; a pop in the same cycle does not free a slot for it.
REQ-021 FSM states SHALL be IDLE and PAINT.
REQ-022 IDLE: if the FIFO is non-empty, pop the head entry into the working registers, clear row/col, and go to PAINT.
REQ-023 Latency: diff sampled at edge N on an empty FIFO and idle FSM SHALL give px_valid=1 in the cycle after edge N+1.
REQ-024 In PAINT, px_valid SHALL be 1, with px_x = cx*CELL_PX+col and px_y = cy*CELL_PX+row, computed without truncation.
REQ-025 While px_valid=1 and px_ready=0, px_x, px_y and px_color SHALL hold stable.
REQ-026 On each accepted pixel, col SHALL increment; at col=CELL_PX-1, col wraps to 0 and row increments (raster order).
REQ-027 On the final pixel (row=col=CELL_PX-1) being accepted: if the FIFO is non-empty, pop the next entry and stay in PAINT (no bubble); otherwise go to IDLE with px_valid=0 in the next cycle.
REQ-028 Colour map SHALL be: 0 -> 0x0000; 1 -> 0xFFFF; 2 -> 0x07E0; 3 -> 0x03E0; 4 -> 0xF800; codes 5..7 -> 0xF81F.
REQ-029 A simultaneous FIFO push and pop SHALL both take effect, and the occupancy SHALL be unchanged.
REQ-030 Each cell SHALL emit exactly CELL_PX*CELL_PX accepted pixels.

Reset
REQ-031 nrst low SHALL asynchronously set: FSM to IDLE, FIFO empty, row/col/cx/cy to 0, px_valid=0, px_x=0, px_y=0, px_color=0, busy=0, overflow=0.
REQ-032 Reset during PAINT SHALL abort the cell with no further pixels, and the queued updates are lost; after reset, scan_en=1.

Configuration
REQ-033 With macro CELL_PAINTER_GRID_LINES_EN defined, pixels with row=0 or col=0 SHALL use colour 0x4208; all other pixels use the object colour.
REQ-034 Without CELL_PAINTER_GRID_LINES_EN, every pixel of a cell SHALL use the object colour; the pixel count and order are unchanged.

Verification
REQ-035 Reset, then a single diff with x=3, y=2, code=4 and px_ready=1: expect 400 pixels, the first at (60,40) and the last at (79,59), all 0xF800, then IDLE and busy=0.
REQ-036 px_ready toggling 1-0 each cycle during a paint: outputs stay stable during the low cycles, and there are exactly 400 accepts.
REQ-037 px_ready=0 with 5 diffs (depth 4): scan_en falls after the 4th diff, the 5th update is dropped, and overflow=1 until reset.
REQ-038 Two queued cells, (0,0) code 1 and (15,11) code 3: the last pixel (19,19) is followed by (300,220) on the next cycle with no gap, colour 0x03E0.
REQ-039 diff with x=15, y=12: nothing is enqueued, overflow stays 0, and px_valid stays 0.
REQ-040 nrst pulsed low mid-PAINT after 37 pixels: px_valid drops immediately, FIFO empty; with GRID_LINES_EN, pixel (0,0) of the next cell is 0x4208.

Source files
------------

// File: rtl/cell_painter.sv
// cell_painter: queues cell updates from the grid scanner and paints each
// cell as CELL_PX x CELL_PX RGB565 pixel writes in raster order through a
// valid/ready pixel sink.
//
// Ports:
//   clk, nrst          clock, asynchronous active-low reset
//   diff, x, y,        cell-update strobe, column (0..15), row (0..11),
//   obj_code           object code (0 blank .. 4 apple)
//   scan_en            FIFO can accept an update (scanner enable)
//   px_valid/px_ready  pixel write handshake
//   px_x, px_y         pixel coordinates (0..319, 0..239)
//   px_color           RGB565 colour
//   busy               FIFO non-empty or painting
//   overflow           sticky: an update was dropped on a full FIFO
//
// Optional feature: define CELL_PAINTER_GRID_LINES_EN to draw the top row
// and left column of every cell in grid colour 0x4208.
module cell_painter #(
  parameter int FIFO_DEPTH = 4,
  parameter int CELL_PX    = 20
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        diff,
  input  logic [3:0]  x,
  input  logic [3:0]  y,
  input  logic [2:0]  obj_code,
  output logic        scan_en,
  output logic        px_valid,
  input  logic        px_ready,
  output logic [8:0]  px_x,
  output logic [7:0]  px_y,
  output logic [15:0] px_color,
  output logic        busy,
  output logic        overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CELL_PX);
  localparam logic [CW-1:0] LAST = CW'(CELL_PX - 1);

  typedef enum logic {IDLE, PAINT} state_t;

  // FIFO: pointers carry one wrap bit to tell full from empty
  logic [10:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        fifo_full, fifo_empty, push, pop;
  logic [10:0] head;

  state_t         state_q, state_d;
  logic [3:0]     cx_q, cx_d, cy_q, cy_d;
  logic [2:0]     code_q, code_d;
  logic [CW-1:0]  row_q, row_d, col_q, col_d;
  logic           px_valid_q, px_valid_d;
  logic [8:0]     px_x_q, px_x_d;
  logic [7:0]     px_y_q, px_y_d;
  logic [15:0]    px_color_q, px_color_d;
  logic           overflow_q;

  function automatic logic [15:0] obj_color(input logic [2:0] c);
    case (c)
      3'd0:    return 16'h0000;
      3'd1:    return 16'hFFFF;
      3'd2:    return 16'h07E0;
      3'd3:    return 16'h03E0;
      3'd4:    return 16'hF800;
      default: return 16'hF81F;
    endcase
  endfunction

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // fullness is judged on the registered state, so a same-cycle pop never
  // makes room for an update arriving while full
  assign push       = diff && (y <= 4'd11) && !fifo_full;
  assign head       = mem_q[rd_ptr_q[AW-1:0]];

  assign scan_en  = !fifo_full;
  assign busy     = !fifo_empty || (state_q != IDLE);
  assign px_valid = px_valid_q;
  assign px_x     = px_x_q;
  assign px_y     = px_y_q;
  assign px_color = px_color_q;
  assign overflow = overflow_q;

  always_comb begin
    state_d    = state_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    code_d     = code_q;
    row_d      = row_q;
    col_d      = col_q;
    px_valid_d = px_valid_q;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          {cx_d, cy_d, code_d} = head;
          row_d      = '0;
          col_d      = '0;
          state_d    = PAINT;
          px_valid_d = 1'b1;
        end
      end
      PAINT: begin
        if (px_ready) begin
          if (col_q == LAST) begin
            col_d = '0;
            if (row_q == LAST) begin
              // chain straight into the next cell without a bubble
              if (!fifo_empty) begin
                pop   = 1'b1;
                {cx_d, cy_d, code_d} = head;
                row_d = '0;
              end else begin
                state_d    = IDLE;
                px_valid_d = 1'b0;
              end
            end else begin
              row_d = row_q + CW'(1);
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // outputs are derived from next-state so they stay frozen while stalled
    px_x_d = 9'(cx_d) * 9'(CELL_PX) + 9'(col_d);
    px_y_d = 8'(cy_d) * 8'(CELL_PX) + 8'(row_d);
`ifdef CELL_PAINTER_GRID_LINES_EN
    if (row_d == '0 || col_d == '0) px_color_d = 16'h4208;
    else                            px_color_d = obj_color(code_d);
`else
    px_color_d = obj_color(code_d);
`endif
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {x, y, obj_code};
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cx_q       <= '0;
      cy_q       <= '0;
      code_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      px_valid_q <= 1'b0;
      px_x_q     <= '0;
      px_y_q     <= '0;
      px_color_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      code_q     <= code_d;
      row_q      <= row_d;
      col_q      <= col_d;
      px_valid_q <= px_valid_d;
      px_x_q     <= px_x_d;
      px_y_q     <= px_y_d;
      px_color_q <= px_color_d;
      if (diff && (y <= 4'd11) && fifo_full) overflow_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cell_painter.sv
module tb_cell_painter;
  localparam int CP = 20;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        diff = 1'b0;
  logic [3:0]  x = '0;
  logic [3:0]  y = '0;
  logic [2:0]  obj_code = '0;
  logic        px_ready = 1'b0;
  logic        scan_en, px_valid, busy, overflow;
  logic [8:0]  px_x;
  logic [7:0]  px_y;
  logic [15:0] px_color;

  int vectors = 0;
  int miscompares = 0;

  cell_painter #(.FIFO_DEPTH(4), .CELL_PX(CP)) dut (
    .clk(clk), .nrst(nrst), .diff(diff), .x(x), .y(y), .obj_code(obj_code),
    .scan_en(scan_en), .px_valid(px_valid), .px_ready(px_ready),
    .px_x(px_x), .px_y(px_y), .px_color(px_color),
    .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] exp_color(input logic [2:0] c, input int r, input int col);
`ifdef CELL_PAINTER_GRID_LINES_EN
    if (r == 0 || col == 0) return 16'h4208;
`endif
    case (c)
      3'd0: return 16'h0000;
      3'd1: return 16'hFFFF;
      3'd2: return 16'h07E0;
      3'd3: return 16'h03E0;
      3'd4: return 16'hF800;
      default: return 16'hF81F;
    endcase
  endfunction

  function automatic logic [33:0] exp_pix(input int cx, input int cy, input logic [2:0] c, input int k);
    int r, col;
    r = (k % (CP*CP)) / CP;
    col = k % CP;
    return {1'b1, 9'(cx*CP + col), 8'(cy*CP + r), exp_color(c, r, col)};
  endfunction

  task automatic do_reset();
    nrst = 1'b0; diff = 1'b0; px_ready = 1'b0;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
  endtask

  task automatic push_cell(input int cx, input int cy, input int c);
    x = 4'(cx); y = 4'(cy); obj_code = 3'(c); diff = 1'b1;
    @(negedge clk);
    diff = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    #1;
    vectors++;
    if ({px_valid, busy, overflow, scan_en, px_x, px_y, px_color} !== {3'b000, 1'b1, 33'd0}) begin
      miscompares++;
      $display("FAIL reset_state: got v=%b b=%b o=%b s=%b x=%0d y=%0d c=%h want 0,0,0,1,0,0,0",
               px_valid, busy, overflow, scan_en, px_x, px_y, px_color);
    end
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_cell();
    int k = 0, cyc = 0;
    logic [33:0] e;
    px_ready = 1'b1;
    push_cell(3, 2, 4);
    vectors++;
    if (px_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL latency_early: px_valid=%b want 0", px_valid);
    end
    @(negedge clk);
    while (k < 400 && cyc < 1000) begin
      e = exp_pix(3, 2, 3'd4, k);
      vectors++;
      if ({px_valid, px_x, px_y, px_color} !== e) begin
        miscompares++;
        $display("FAIL single_pix%0d: got v=%b (%0d,%0d) %h want (%0d,%0d) %h",
                 k, px_valid, px_x, px_y, px_color, e[32:24], e[23:16], e[15:0]);
      end
      if (px_valid) k++;
      cyc++;
      @(negedge clk);
    end
    vectors++;
    if ({k == 400, px_valid, busy} !== 3'b100) begin
      miscompares++;
      $display("FAIL single_end: accepts=%0d v=%b busy=%b want 400,0,0", k, px_valid, busy);
    end
  endtask

  task automatic test_ready_toggle();
    int k = 0, cyc = 0;
    logic ph = 1'b1, held = 1'b0;
    logic [32:0] prev = '0;
    logic [33:0] e;
    px_ready = 1'b0;
    push_cell(1, 1, 2);
    while (!px_valid && cyc < 10) begin @(negedge clk); cyc++; end
    cyc = 0;
    while (k < 400 && cyc < 2000) begin
      e = exp_pix(1, 1, 3'd2, k);
      vectors++;
      if ({px_valid, px_x, px_y, px_color} !== e) begin
        miscompares++;
        $display("FAIL toggle_pix%0d: got v=%b (%0d,%0d) %h want (%0d,%0d) %h",
                 k, px_valid, px_x, px_y, px_color, e[32:24], e[23:16], e[15:0]);
      end
      if (held) begin
        vectors++;
        if ({px_x, px_y, px_color} !== prev) begin
          miscompares++;
          $display("FAIL toggle_hold%0d: got %h want %h", k, {px_x, px_y, px_color}, prev);
        end
      end
      px_ready = ph;
      held = !ph;
      prev = {px_x, px_y, px_color};
      if (px_valid && ph) k++;
      ph = !ph;
      cyc++;
      @(negedge clk);
    end
    px_ready = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({k == 400, px_valid, busy} !== 3'b100) begin
      miscompares++;
      $display("FAIL toggle_end: accepts=%0d v=%b busy=%b want 400,0,0", k, px_valid, busy);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    px_ready = 1'b0;
    push_cell(0, 0, 0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      push_cell(i, 1, 1);
      vectors++;
      if ({scan_en, overflow} !== {i < 3, i == 4}) begin
        miscompares++;
        $display("FAIL overflow_diff%0d: scan_en=%b overflow=%b want %b,%b",
                 i, scan_en, overflow, i < 3, i == 4);
      end
    end
    px_ready = 1'b1;
    repeat (10) @(negedge clk);
    vectors++;
    if (overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_sticky: overflow=%b want 1", overflow);
    end
    do_reset();
    vectors++;
    if ({overflow, scan_en, px_valid, busy} !== 4'b0100) begin
      miscompares++;
      $display("FAIL overflow_cleared: o=%b s=%b v=%b b=%b want 0,1,0,0",
               overflow, scan_en, px_valid, busy);
    end
  endtask

  task automatic test_back_to_back();
    int k = 0, cyc = 0;
    logic [33:0] e;
    px_ready = 1'b0;
    push_cell(0, 0, 1);
    push_cell(15, 11, 3);
    while (k < 800 && cyc < 2000) begin
      e = (k < 400) ? exp_pix(0, 0, 3'd1, k) : exp_pix(15, 11, 3'd3, k);
      vectors++;
      if ({px_valid, px_x, px_y, px_color} !== e) begin
        miscompares++;
        $display("FAIL b2b_pix%0d: got v=%b (%0d,%0d) %h want (%0d,%0d) %h",
                 k, px_valid, px_x, px_y, px_color, e[32:24], e[23:16], e[15:0]);
      end
      px_ready = 1'b1;
      if (px_valid) k++;
      cyc++;
      @(negedge clk);
    end
    vectors++;
    if ({k == 800, px_valid, busy} !== 3'b100) begin
      miscompares++;
      $display("FAIL b2b_end: accepts=%0d v=%b busy=%b want 800,0,0", k, px_valid, busy);
    end
  endtask

  task automatic test_bad_coord();
    push_cell(15, 12, 4);
    repeat (3) begin
      vectors++;
      if ({px_valid, busy, overflow, scan_en} !== 4'b0001) begin
        miscompares++;
        $display("FAIL bad_coord: v=%b b=%b o=%b s=%b want 0,0,0,1",
                 px_valid, busy, overflow, scan_en);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_paint();
    int k = 0, cyc = 0;
    logic [33:0] e;
    px_ready = 1'b0;
    push_cell(5, 5, 0);
    push_cell(6, 6, 1);
    while (k < 37 && cyc < 100) begin
      px_ready = 1'b1;
      if (px_valid) k++;
      cyc++;
      @(negedge clk);
    end
    #2 nrst = 1'b0;
    #1;
    vectors++;
    if ({k == 37, px_valid, busy, scan_en, px_x, px_y, px_color} !== {4'b1001, 33'd0}) begin
      miscompares++;
      $display("FAIL mid_reset: accepts=%0d v=%b b=%b s=%b x=%0d y=%0d c=%h want 37,0,0,1,0,0,0",
               k, px_valid, busy, scan_en, px_x, px_y, px_color);
    end
    @(negedge clk);
    nrst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if ({px_valid, busy} !== 2'b00) begin
        miscompares++;
        $display("FAIL mid_reset_lost: v=%b b=%b want 0,0", px_valid, busy);
      end
    end
    push_cell(2, 3, 4);
    @(negedge clk);
    e = exp_pix(2, 3, 3'd4, 0);
    vectors++;
    if ({px_valid, px_x, px_y, px_color} !== e) begin
      miscompares++;
      $display("FAIL after_reset_pix0: got v=%b (%0d,%0d) %h want (%0d,%0d) %h",
               px_valid, px_x, px_y, px_color, e[32:24], e[23:16], e[15:0]);
    end
  endtask

  initial begin
    test_reset();
    test_single_cell();
    test_ready_toggle();
    test_overflow();
    test_back_to_back();
    test_bad_coord();
    test_reset_mid_paint();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
